// File: rtl/ls_serial_tx.sv
// Parallel-in, serial-out asynchronous frame transmitter.
// Frame: start bit, LSB-first data, optional parity bit, stop bit. All outputs are registered.
module ls_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    // state    | meaning
    // S_IDLE   | line high, ready for a word
    // S_START  | start bit (low)
    // S_DATA   | data bits, LSB first
    // S_PARITY | parity bit (only when parity is enabled)
    // S_STOP   | stop bit (high); done pulses on exit
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_TC = BIT_W'(DATA_W - 1);
    // PARITY=3 falls through to "no parity".
    localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam logic PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state, state_nx;
    logic [DIV_W-1:0]    div_cnt, div_nx;
    logic [BIT_W-1:0]    bit_cnt, bit_nx;
    logic [DATA_W-1:0]   shift, shift_nx;
    logic                par_bit, par_nx;
    logic                tx_nx, ready_nx, busy_nx, done_nx;
    logic                div_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            bit_cnt <= bit_nx;
            shift   <= shift_nx;
            par_bit <= par_nx;
            tx      <= tx_nx;
            ready   <= ready_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    // Outputs are computed for the next cycle so they are visible right after the edge.
    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        shift_nx = shift;
        par_nx   = par_bit;
        tx_nx    = tx;
        ready_nx = ready;
        busy_nx  = busy;
        done_nx  = 1'b0;
        div_tc   = (div_cnt == DIV_TC);

        if (state != S_IDLE) begin
            div_nx = div_tc ? '0 : div_cnt + DIV_W'(1);
        end

        case (state)
            S_IDLE: begin
                tx_nx    = 1'b1;
                ready_nx = 1'b1;
                busy_nx  = 1'b0;
                div_nx   = '0;
                bit_nx   = '0;
                if (valid && ready) begin
                    shift_nx = data;
                    par_nx   = (^data) ^ PAR_ODD;
                    state_nx = S_START;
                    tx_nx    = 1'b0;
                    ready_nx = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            S_START: begin
                if (div_tc) begin
                    state_nx = S_DATA;
                    tx_nx    = shift[0];
                    bit_nx   = '0;
                end
            end
            S_DATA: begin
                if (div_tc) begin
                    shift_nx = shift >> 1;
                    if (bit_cnt == BIT_TC) begin
                        bit_nx = '0;
                        if (PAR_EN) begin
                            state_nx = S_PARITY;
                            tx_nx    = par_bit;
                        end else begin
                            state_nx = S_STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bit_nx = bit_cnt + BIT_W'(1);
                        tx_nx  = shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (div_tc) begin
                    state_nx = S_STOP;
                    tx_nx    = 1'b1;
                end
            end
            S_STOP: begin
                tx_nx = 1'b1;
                if (div_tc) begin
                    state_nx = S_IDLE;
                    ready_nx = 1'b1;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                tx_nx    = 1'b1;
                ready_nx = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end
endmodule

// File: doc/ls_serial_tx.md
# ls_serial_tx

Parallel-in, serial-out frame transmitter for the TTL-style peripheral library. It accepts a parallel byte from the CPU-side datapath with a valid/ready handshake and shifts it out on a single line as an asynchronous-serial frame: start bit, LSB-first data, optional parity, stop bit. It is the transmit end of the board's serial link and behaves like a 74LS166-style shift register with frame control, a bit-time divider and a bit counter around it.

## Interface
- DATA_W, 8: data bits per frame; legal range 5..8.
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 1..65535.
- PARITY, 0: parity mode. 0 = none, 1 = even, 2 = odd.

- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk upstream.
- data  in  DATA_W  parallel word; sampled only on the accept edge.
- valid  in  1  the producer has a word on data.
- ready  out  1  the transmitter can accept a word; high only in IDLE.
- tx  out  1  serial line output; idles high.
- busy  out  1  a frame is in progress (START..STOP).
- done  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- All outputs are registered. Reset values: tx=1, ready=1, busy=0, done=0, state=IDLE, counters=0, shift register=0.
- Accept: a rising edge with valid=1 and ready=1. data is latched into the shift register, and the parity bit is computed from the latched data (even: XOR of the bits; odd: its inverse). Later changes on data have no effect. While ready=0, valid is ignored and not queued.
- States:
  - IDLE: tx=1, ready=1, busy=0. Accept moves to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]; the register shifts right every CLKS_PER_BIT cycles. After DATA_W bits it goes to PARITY when PARITY!=0, otherwise to STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with done=1 for exactly one cycle.
- Divider counts 0..CLKS_PER_BIT-1 and wraps. With CLKS_PER_BIT=1 the divider is always at terminal count and each bit lasts one cycle.
- Bit counter counts 0..DATA_W-1 in DATA only. Width is $clog2(DATA_W), with a minimum of 1.
- Frame length is F = DATA_W + 2 + (PARITY!=0) bits.
- Reset mid-frame: the frame is abandoned immediately and asynchronously. tx returns to 1 with no glitch low, and done is not pulsed.
- Illegal PARITY value (3) is treated as 0.

## Timing
- Accept edge E0: at E0, ready→0, busy→1 and tx→0 (start bit), all visible in the cycle after E0.
- Bit n of the frame (n=0 is the start bit) drives tx from edge E0+n·CLKS_PER_BIT to edge E0+(n+1)·CLKS_PER_BIT.
- At edge E0+F·CLKS_PER_BIT: ready→1, busy→0 and done→1; tx stays 1. done clears at the next edge.
- Earliest next accept is edge E0+F·CLKS_PER_BIT+1. With valid held high, the frame-start period is F·CLKS_PER_BIT+1 cycles, so consecutive frames are separated by exactly one extra idle-high cycle.
- ready and done are never high in the same cycle as busy.
- Latency from the accept edge to the start of the start bit on tx is one cycle (register output).

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Required: tx=1, ready=1, busy=0, done=0, and they remain so with valid=0 for 20 cycles.
- Basic frame (DATA_W=8, CPB=4, PARITY=0): send data=0xA5. tx, sampled every 4 cycles from E0, reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 10100101, stop). done pulses once at E0+40, and ready returns at E0+40.
- Parity (PARITY=1 then PARITY=2, CPB=1): send data=0x07. The 11-bit frame is 0,1,1,1,0,0,0,0,0,p,1 with p=1 for even and p=0 for odd. done occurs at E0+11.
- Back-to-back with ignore (CPB=2): hold valid=1 with data=0x3C, and change data to 0xFF mid-frame. The first frame still carries 0x3C. The second frame carries 0xFF, its start bit begins at E0+21, and tx is high for exactly 1 cycle between the two frames.
- Reset mid-frame (CPB=4): assert rst_n=0 during data bit 3 of 0x00, while tx=0. Required: tx=1 in the same cycle, no done pulse, ready=1 after release, and a following frame with 0x55 is transmitted correctly.
- Minimum divider (CPB=1, PARITY=0): send 0xFF then 0x00 with valid held high. Required waveform: 0,1×8,1,1(gap),0,0×8,1. busy drops for exactly one cycle between the frames.
